// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, derived totals and
// sync-window bounds. Renderers import this for their region decoding.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int FCNT_W  = 16;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Inclusive sync windows in pixel / line coordinates.
    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // True when v lies in the inclusive range [lo, hi].
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: a phase counter over 0..CLK_DIV-1 and a
// registered one-clk-wide enable that follows the last phase by one cycle.
module pix_ce_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            pix_en_q, pix_en_d;

    // Next phase wraps after the last phase; the enable marks the wrap cycle.
    always_comb begin
        phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        pix_en_d = (phase_q == PH_LAST);
    end

    // Phase and enable registers, forced to phase 0 / idle on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= '0;
            pix_en_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: h/v coordinate counters, sync and active-video
// flags registered together with the coordinates they describe, frame marker
// and frame counter.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] hsync,
    output logic [COORD_W-1:0] vsync,
    output logic               hs_n,
    output logic               vs_n,
    output logic               video_on,
    output logic               frame_start,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    localparam coord_t H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam coord_t V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam coord_t H_ACT    = COORD_W'(H_ACTIVE);
    localparam coord_t V_ACT    = COORD_W'(V_ACTIVE);
    localparam coord_t HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic pix_en_w;

    pix_ce_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_ce_div (
        .clk   (clk),
        .reset (reset),
        .pix_en(pix_en_w)
    );

    coord_t              h_q, h_d;
    coord_t              v_q, v_d;
    logic                hs_n_q, hs_n_d;
    logic                vs_n_q, vs_n_d;
    logic                video_on_q, video_on_d;
    logic                frame_start_q, frame_start_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    // Advance the coordinates on a pixel enable, then derive every flag from
    // the new position so flags and coordinates land on the same edge.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_w) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hs_n_d        = in_window(h_d, HS_START, HS_END) ? HS_POL : !HS_POL;
        vs_n_d        = in_window(v_d, VS_START, VS_END) ? VS_POL : !VS_POL;
        video_on_d    = (h_d < H_ACT) && (v_d < V_ACT);
        frame_start_d = pix_en_w && (h_d == '0) && (v_d == '0);
        frame_cnt_d   = frame_cnt_q + FCNT_W'(frame_start_d);
    end

    // Output registers; reset parks at the last pixel so the first enable
    // wraps straight into (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            hs_n_q        <= !HS_POL;
            vs_n_q        <= !VS_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hs_n_q        <= hs_n_d;
            vs_n_q        <= vs_n_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_en      = pix_en_w;
    assign hsync       = h_q;
    assign vsync       = v_q;
    assign hs_n        = hs_n_q;
    assign vs_n        = vs_n_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing at CLK_DIV=2 plus two reduced
// timings (CLK_DIV=1 with inverted polarity, CLK_DIV=3) compared each cycle
// against an arithmetic model of pixel position versus elapsed clocks.
module tb_vga_sync_gen;

    typedef struct {
        int cd, ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int x, y;
        bit pe, hs_n, vs_n, von, fs;
        int fc;
    } exp_t;

    typedef struct {
        int   t;
        exp_t e;
    } vec_t;

    localparam int NV = 17;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       a_pe, a_hs_n, a_vs_n, a_von, a_fs;
    logic [9:0] a_x, a_y;
    logic [15:0] a_fc;
    logic       b_pe, b_hs_n, b_vs_n, b_von, b_fs;
    logic [9:0] b_x, b_y;
    logic [15:0] b_fc;
    logic       c_pe, c_hs_n, c_vs_n, c_von, c_fs;
    logic [9:0] c_x, c_y;
    logic [15:0] c_fc;

    int vectors = 0;
    int miscompares = 0;

    cfg_t cfg_a, cfg_b, cfg_c;
    vec_t tbl[NV];

    // Clock generation.
    always #5 clk = ~clk;

    vga_sync_gen #(.CLK_DIV(2)) u_dut_a (
        .clk(clk), .reset(rst_a), .pix_en(a_pe), .hsync(a_x), .vsync(a_y),
        .hs_n(a_hs_n), .vs_n(a_vs_n), .video_on(a_von), .frame_start(a_fs),
        .frame_cnt(a_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .pix_en(b_pe), .hsync(b_x), .vsync(b_y),
        .hs_n(b_hs_n), .vs_n(b_vs_n), .video_on(b_von), .frame_start(b_fs),
        .frame_cnt(b_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_c (
        .clk(clk), .reset(rst_c), .pix_en(c_pe), .hsync(c_x), .vsync(c_y),
        .hs_n(c_hs_n), .vs_n(c_vs_n), .video_on(c_von), .frame_start(c_fs),
        .frame_cnt(c_fc)
    );

    // Expected outputs t clocks after reset release: pixel enables land on
    // multiples of CLK_DIV, each completed enable advances a linear pixel index
    // that starts one before (0,0).
    function automatic exp_t model(cfg_t c, int t);
        exp_t e;
        int ht, vt, f, n, p;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        f  = ht * vt;
        n  = (t >= 1) ? (t - 1) / c.cd : 0;
        p  = (n + f - 1) % f;
        e.x    = p % ht;
        e.y    = p / ht;
        e.pe   = (t >= c.cd) && (t % c.cd == 0);
        e.fs   = (n >= 1) && (p == 0) && (t - 1 >= c.cd) && ((t - 1) % c.cd == 0);
        e.fc   = (n >= 1) ? (((n - 1) / f) + 1) % 65536 : 0;
        e.hs_n = ((e.x >= c.ha + c.hfp) && (e.x < c.ha + c.hfp + c.hs)) ? c.hpol : !c.hpol;
        e.vs_n = ((e.y >= c.va + c.vfp) && (e.y < c.va + c.vfp + c.vs)) ? c.vpol : !c.vpol;
        e.von  = (e.x < c.ha) && (e.y < c.va);
        return e;
    endfunction

    function automatic exp_t mk(int x, int y, bit pe, bit hs, bit vs, bit von, bit fs, int fc);
        exp_t e;
        e.x = x; e.y = y; e.pe = pe; e.hs_n = hs; e.vs_n = vs;
        e.von = von; e.fs = fs; e.fc = fc;
        return e;
    endfunction

    // Compare one DUT's outputs against an expected record.
    task automatic check_dut(int sel, string tag, int t, exp_t e);
        logic pe, hs, vs, von, fs;
        logic [9:0] x, y;
        logic [15:0] fc;
        case (sel)
            0: begin pe = a_pe; x = a_x; y = a_y; hs = a_hs_n; vs = a_vs_n; von = a_von; fs = a_fs; fc = a_fc; end
            1: begin pe = b_pe; x = b_x; y = b_y; hs = b_hs_n; vs = b_vs_n; von = b_von; fs = b_fs; fc = b_fc; end
            default: begin pe = c_pe; x = c_x; y = c_y; hs = c_hs_n; vs = c_vs_n; von = c_von; fs = c_fs; fc = c_fc; end
        endcase
        vectors++;
        if (int'(x) != e.x || int'(y) != e.y || pe != e.pe || hs != e.hs_n || vs != e.vs_n ||
            von != e.von || fs != e.fs || int'(fc) != e.fc) begin
            miscompares++;
            $display("FAIL %s t=%0d: got x=%0d y=%0d pe=%0b hs_n=%0b vs_n=%0b von=%0b fs=%0b fc=%0d; want x=%0d y=%0d pe=%0b hs_n=%0b vs_n=%0b von=%0b fs=%0b fc=%0d",
                     tag, t, x, y, pe, hs, vs, von, fs, fc,
                     e.x, e.y, e.pe, e.hs_n, e.vs_n, e.von, e.fs, e.fc);
        end
    endtask

    task automatic check_int(string tag, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic set_rst(int sel, logic v);
        case (sel)
            0: rst_a = v;
            1: rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    // Called at a negedge; returns at the negedge of cycle 0 after release.
    task automatic do_reset(int sel);
        set_rst(sel, 1'b1);
        @(negedge clk);
        set_rst(sel, 1'b0);
    endtask

    task automatic run_model(int sel, cfg_t c, int len, string tag);
        for (int t = 0; t < len; t++) begin
            check_dut(sel, tag, t, model(c, t));
            @(negedge clk);
        end
    endtask

    // Bounded wait for frame_start on dut_b; returns cycles waited.
    task automatic wait_fs_b(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            if (b_fs) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int ta, hs_lo, von_lo, tix, guard, cyc, cyc2, len;
        bit ok;
        exp_t e;

        cfg_a = '{cd: 2, ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, hpol: 1'b0, vpol: 1'b0};
        cfg_b = '{cd: 1, ha: 8, hfp: 2, hs: 3, hbp: 3, va: 6, vfp: 2, vs: 2, vbp: 2, hpol: 1'b1, vpol: 1'b1};
        cfg_c = '{cd: 3, ha: 10, hfp: 1, hs: 2, hbp: 1, va: 4, vfp: 1, vs: 1, vbp: 1, hpol: 1'b0, vpol: 1'b0};

        // Hand-derived checkpoints for the full-size timing (t = clocks after release).
        tbl[0]  = '{0,     mk(799, 524, 0, 1, 1, 0, 0, 0)};
        tbl[1]  = '{1,     mk(799, 524, 0, 1, 1, 0, 0, 0)};
        tbl[2]  = '{2,     mk(799, 524, 1, 1, 1, 0, 0, 0)};
        tbl[3]  = '{3,     mk(0,   0,   0, 1, 1, 1, 1, 1)};
        tbl[4]  = '{4,     mk(0,   0,   1, 1, 1, 1, 0, 1)};
        tbl[5]  = '{5,     mk(1,   0,   0, 1, 1, 1, 0, 1)};
        tbl[6]  = '{1282,  mk(639, 0,   1, 1, 1, 1, 0, 1)};
        tbl[7]  = '{1283,  mk(640, 0,   0, 1, 1, 0, 0, 1)};
        tbl[8]  = '{1314,  mk(655, 0,   1, 1, 1, 0, 0, 1)};
        tbl[9]  = '{1315,  mk(656, 0,   0, 0, 1, 0, 0, 1)};
        tbl[10] = '{1506,  mk(751, 0,   1, 0, 1, 0, 0, 1)};
        tbl[11] = '{1507,  mk(752, 0,   0, 1, 1, 0, 0, 1)};
        tbl[12] = '{1602,  mk(799, 0,   1, 1, 1, 0, 0, 1)};
        tbl[13] = '{1603,  mk(0,   1,   0, 1, 1, 1, 0, 1)};
        tbl[14] = '{28802, mk(799, 17,  1, 1, 1, 0, 0, 1)};
        tbl[15] = '{28803, mk(0,   18,  0, 1, 1, 1, 0, 1)};
        tbl[16] = '{28804, mk(0,   18,  1, 1, 1, 1, 0, 1)};

        // Hold all resets across two edges, then release dut_a.
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;

        // Full-size scan through line 18: model every cycle, table at checkpoints.
        hs_lo = 0;
        von_lo = 0;
        tix = 0;
        ta = 0;
        for (int t = 0; t <= 29000; t++) begin
            check_dut(0, "a_model", t, model(cfg_a, t));
            if (tix < NV && tbl[tix].t == t) begin
                check_dut(0, $sformatf("a_table%0d", tix), t, tbl[tix].e);
                tix++;
            end
            if (t >= 1603 && t <= 3202) begin
                if (!a_hs_n) hs_lo++;
                if (!a_von) von_lo++;
            end
            @(negedge clk);
            ta = t + 1;
        end
        check_int("a_line1_hs_low_clks", hs_lo, 192);
        check_int("a_line1_blank_clks", von_lo, 320);

        // Reset mid-pixel at x=300 on a non-enable cycle.
        guard = 0;
        e = model(cfg_a, ta);
        while (!(e.x == 300 && !e.pe) && guard < 2000) begin
            check_dut(0, "a_seek", ta, e);
            @(negedge clk);
            ta++;
            guard++;
            e = model(cfg_a, ta);
        end
        if (guard >= 2000) begin
            miscompares++;
            $display("FAIL a_seek_timeout: got no x=300 within %0d cycles, want one", guard);
        end
        check_dut(0, "a_pre_reset", ta, e);
        do_reset(0);
        check_dut(0, "a_midreset", 0, mk(799, 524, 0, 1, 1, 0, 0, 0));
        run_model(0, cfg_a, 1700, "a_restart");
        rst_a = 1'b1;

        // Reduced timing, CLK_DIV=1, inverted sync polarity.
        do_reset(1);
        run_model(1, cfg_b, 600, "b_model");
        do_reset(1);
        wait_fs_b(cyc, ok);
        check_int("b_first_fs_found", int'(ok), 1);
        check_int("b_first_fs_cycle", cyc, 2);
        @(negedge clk);
        wait_fs_b(cyc2, ok);
        check_int("b_second_fs_found", int'(ok), 1);
        check_int("b_frame_period", cyc2 + 1, 192);

        // Frame counter wrap: just past a frame start, preload 65535.
        @(negedge clk);
        force u_dut_b.frame_cnt_q = 16'hFFFF;
        #1;
        release u_dut_b.frame_cnt_q;
        @(negedge clk);
        check_int("b_fc_preload_held", int'(b_fc), 65535);
        wait_fs_b(cyc, ok);
        check_int("b_wrap_fs_found", int'(ok), 1);
        check_int("b_fc_wrap", int'(b_fc), 0);
        @(negedge clk);
        check_int("b_fs_one_clk", int'(b_fs), 0);

        // Randomised run lengths with resets at arbitrary positions.
        for (int r = 0; r < 4; r++) begin
            do_reset(1);
            len = $urandom_range(20, 900);
            run_model(1, cfg_b, len, "b_rand");
        end
        rst_b = 1'b1;

        // Reduced timing, CLK_DIV=3: random resets catch every divider phase.
        for (int r = 0; r < 5; r++) begin
            do_reset(2);
            len = $urandom_range(10, 1200);
            run_model(2, cfg_c, len, "c_rand");
        end
        rst_c = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
